// File: rtl/hamming_dec_arbiter_if.sv
// Handshake bundle between two codeword requesters, the shared decoder and its consumer.
// The master side drives codewords and out_ready; the slave side is the decoder.
interface hamming_dec_arbiter_if;
  logic        req0_valid;
  logic [14:0] req0_cw;
  logic        req0_ready;
  logic        req1_valid;
  logic [14:0] req1_cw;
  logic        req1_ready;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_data;
  logic        out_src;
  logic [3:0]  out_syndrome;
  logic        out_corrected;

  modport master (
    output req0_valid, req0_cw, req1_valid, req1_cw, out_ready,
    input  req0_ready, req1_ready, out_valid, out_data, out_src, out_syndrome, out_corrected
  );
  modport slave (
    input  req0_valid, req0_cw, req1_valid, req1_cw, out_ready,
    output req0_ready, req1_ready, out_valid, out_data, out_src, out_syndrome, out_corrected
  );
endinterface

// File: rtl/hamming_dec_arbiter.sv
// Round-robin shared Hamming(15,11) SEC decoder with one registered output slot
// and a saturating count of corrected words.
module hamming_dec_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  hamming_dec_arbiter_if.slave bus,
  input  logic               clr_cnt,
  output logic [CNT_W-1:0]   corr_cnt
);
  typedef enum logic {EMPTY, FULL} state_t;

  state_t             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic [10:0]        data_q, data_d;
  logic               src_q, src_d;
  logic [3:0]         syn_q, syn_d;
  logic               corr_q, corr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [1:0]         vld;
  logic [1:0][14:0]   cw;
  logic               can_accept, accept, gnt;
  logic [14:0]        cw_sel, cw_fix, flip;
  logic [3:0]         syn;

  assign vld = {bus.req1_valid, bus.req0_valid};
  assign cw  = {bus.req1_cw, bus.req0_cw};

  assign can_accept = (state_q == EMPTY) | bus.out_ready;
  // Under contention the grant alternates; a lone requester always wins.
  assign gnt        = (vld == 2'b11) ? ~last_grant_q : vld[1];
  assign accept     = can_accept & (|vld);

  assign bus.req0_ready = accept & ~gnt;
  assign bus.req1_ready = accept &  gnt;

  assign cw_sel = cw[gnt];
  assign syn[0] = ^(cw_sel & 15'h5555);
  assign syn[1] = ^(cw_sel & 15'h6666);
  assign syn[2] = ^(cw_sel & 15'h7878);
  assign syn[3] = ^(cw_sel & 15'h7F80);
  // Syndrome is the 1-based position of the flipped bit; parity positions fall outside the data.
  assign flip   = (syn == 4'd0) ? 15'd0 : (15'd1 << (syn - 4'd1));
  assign cw_fix = cw_sel ^ flip;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    data_d       = data_q;
    src_d        = src_q;
    syn_d        = syn_q;
    corr_d       = corr_q;
    cnt_d        = cnt_q;
    if (accept) begin
      state_d      = FULL;
      last_grant_d = gnt;
      data_d       = {cw_fix[14:8], cw_fix[6:4], cw_fix[2]};
      src_d        = gnt;
      syn_d        = syn;
      corr_d       = (syn != 4'd0);
    end else if (bus.out_ready) begin
      state_d = EMPTY;
    end
    if (clr_cnt)
      cnt_d = '0;
    else if (accept && (syn != 4'd0) && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      last_grant_q <= 1'b1;
      data_q       <= '0;
      src_q        <= 1'b0;
      syn_q        <= '0;
      corr_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      data_q       <= data_d;
      src_q        <= src_d;
      syn_q        <= syn_d;
      corr_q       <= corr_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.out_valid     = (state_q == FULL);
  assign bus.out_data      = data_q;
  assign bus.out_src       = src_q;
  assign bus.out_syndrome  = syn_q;
  assign bus.out_corrected = corr_q;
  assign corr_cnt          = cnt_q;
endmodule

// File: tb/tb_hamming_dec_arbiter.sv
// Randomized scoreboard bench for the shared Hamming decoder: a position-arithmetic
// reference predicts every accept, result and counter value.
module tb_hamming_dec_arbiter;
  localparam int CNT_W = 2;

  typedef struct packed {
    logic [10:0] data;
    logic        src;
    logic [3:0]  syn;
    logic        corr;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr_cnt = 1'b0;
  logic [CNT_W-1:0] corr_cnt;
  hamming_dec_arbiter_if bus();

  hamming_dec_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .clr_cnt(clr_cnt), .corr_cnt(corr_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  res_t       sb[$];
  logic [14:0] w0[$], w1[$];
  logic       m_full = 1'b0, m_last = 1'b1, acc0 = 1'b0, acc1 = 1'b0;
  logic [CNT_W-1:0] m_cnt = '0;
  logic       m_g, m_acc;
  res_t       m_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Syndrome = XOR of the 1-based positions of all set bits.
  function automatic logic [3:0] pos_syn(input logic [14:0] c);
    logic [3:0] s;
    s = 4'd0;
    for (int i = 0; i < 15; i++) if (c[i]) s = s ^ 4'(i + 1);
    return s;
  endfunction

  function automatic logic is_pow2(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  function automatic res_t ref_dec(input logic [14:0] c, input logic src);
    res_t r;
    logic [14:0] f;
    int k;
    r.syn  = pos_syn(c);
    r.corr = (r.syn != 0);
    r.src  = src;
    f = c;
    if (r.syn != 0) f[r.syn - 1] = ~f[r.syn - 1];
    r.data = '0;
    k = 0;
    for (int p = 1; p <= 15; p++)
      if (!is_pow2(p)) begin r.data[k] = f[p - 1]; k++; end
    return r;
  endfunction

  function automatic logic [14:0] encode(input logic [10:0] d);
    logic [14:0] c;
    logic [3:0] s;
    int k;
    c = '0;
    k = 0;
    for (int p = 1; p <= 15; p++)
      if (!is_pow2(p)) begin c[p - 1] = d[k]; k++; end
    s = pos_syn(c);
    for (int j = 0; j < 4; j++) if (s[j]) c[(1 << j) - 1] = 1'b1;
    return c;
  endfunction

  function automatic logic [14:0] rand_word();
    logic [14:0] c;
    int e;
    c = encode(11'($urandom));
    e = $urandom_range(0, 3);
    if (e >= 1) c[$urandom_range(0, 14)] ^= 1'b1;
    if (e == 3) c[$urandom_range(0, 14)] ^= 1'b1;
    return c;
  endfunction

  // Monitor / scoreboard: predicts handshakes from the arbitration rules and checks outputs.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      m_full = 1'b0; m_last = 1'b1; m_cnt = '0; acc0 = 1'b0; acc1 = 1'b0;
    end else begin
      m_g   = (bus.req0_valid && bus.req1_valid) ? !m_last : bus.req1_valid;
      m_acc = (bus.req0_valid || bus.req1_valid) && (!m_full || bus.out_ready);
      chk("req0_ready", 32'(bus.req0_ready), 32'(m_acc && !m_g));
      chk("req1_ready", 32'(bus.req1_ready), 32'(m_acc && m_g));
      chk("out_valid", 32'(bus.out_valid), 32'(m_full));
      if (m_full && sb.size() > 0) begin
        chk("out_data", 32'(bus.out_data), 32'(sb[0].data));
        chk("out_src", 32'(bus.out_src), 32'(sb[0].src));
        chk("out_syndrome", 32'(bus.out_syndrome), 32'(sb[0].syn));
        chk("out_corrected", 32'(bus.out_corrected), 32'(sb[0].corr));
      end
      chk("corr_cnt", 32'(corr_cnt), 32'(m_cnt));
      if (m_full && bus.out_ready) void'(sb.pop_front());
      if (m_acc) begin
        m_e = ref_dec(m_g ? bus.req1_cw : bus.req0_cw, m_g);
        sb.push_back(m_e);
        m_last = m_g;
        if (!clr_cnt && m_e.corr && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
      end
      if (clr_cnt) m_cnt = '0;
      m_full = m_acc || (m_full && !bus.out_ready);
      acc0 = m_acc && !m_g;
      acc1 = m_acc && m_g;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (acc0 && w0.size() > 0) void'(w0.pop_front());
    if (acc1 && w1.size() > 0) void'(w1.pop_front());
    bus.req0_valid = (w0.size() > 0);
    bus.req0_cw    = (w0.size() > 0) ? w0[0] : 15'h0;
    bus.req1_valid = (w1.size() > 0);
    bus.req1_cw    = (w1.size() > 0) ? w1[0] : 15'h0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_corr_cnt", 32'(corr_cnt), 32'h0);
    chk("rst_out_data", 32'(bus.out_data), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_until_empty(input int budget);
    int n;
    n = 0;
    while ((w0.size() > 0 || w1.size() > 0) && n < budget) begin step(); n++; end
    chk("drain_budget", 32'(w0.size() + w1.size()), 32'h0);
  endtask

  initial begin
    bus.req0_valid = 1'b0; bus.req0_cw = '0;
    bus.req1_valid = 1'b0; bus.req1_cw = '0;
    bus.out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_init_valid", 32'(bus.out_valid), 32'h0);
    rst_n = 1'b1;

    // Stream on requester 0, reset mid-stream, then a clean zero word.
    for (int i = 0; i < 4; i++) w0.push_back(rand_word());
    bus.out_ready = 1'b0;
    repeat (3) step();
    do_reset();
    w0.delete();
    bus.out_ready = 1'b1;
    w0.push_back(15'h0000);
    w0.push_back(15'h0040);
    run_until_empty(20);
    w1.push_back(15'h7FFF);
    run_until_empty(20);
    repeat (2) step();

    // Contention right after reset: sources must alternate starting with 0.
    do_reset();
    for (int i = 0; i < 4; i++) begin w0.push_back(rand_word()); w1.push_back(rand_word()); end
    step();
    run_until_empty(30);
    repeat (2) step();

    // Backpressure: hold a result for 3 cycles with both requesters waiting.
    for (int i = 0; i < 3; i++) begin w0.push_back(rand_word()); w1.push_back(rand_word()); end
    step();
    bus.out_ready = 1'b0;
    repeat (3) step();
    bus.out_ready = 1'b1;
    run_until_empty(30);
    repeat (2) step();

    // Saturation then clear coinciding with an erroneous accept.
    for (int i = 0; i < 5; i++) w0.push_back(15'h0001 << i);
    run_until_empty(30);
    repeat (2) step();
    w0.push_back(15'h0100);
    step();
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    repeat (3) step();

    // Randomized traffic with backpressure, clears and a mid-stream reset.
    for (int c = 0; c < 800; c++) begin
      if (c == 400) do_reset();
      if (w0.size() < 2 && $urandom_range(0, 1) == 1) w0.push_back(rand_word());
      if (w1.size() < 2 && $urandom_range(0, 1) == 1) w1.push_back(rand_word());
      bus.out_ready = ($urandom_range(0, 3) != 0);
      clr_cnt = ($urandom_range(0, 39) == 0);
      step();
    end
    clr_cnt = 1'b0;
    bus.out_ready = 1'b1;
    run_until_empty(40);
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
